// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: FSM state codes and requester slot IDs.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY_IF = 2'd1;
  localparam logic [1:0] ST_BUSY_D  = 2'd2;

  // Requester slots in the request/grant vectors.
  localparam int REQ_IF  = 0;
  localparam int REQ_D   = 1;
  localparam int NUM_REQ = 2;

endpackage

// File: rtl/mem_port_arbiter_arb_prio_pick.sv
// Fixed-priority D-over-IF pick with a saturating IF starvation counter that forces an IF win.
module arb_prio_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             force_if;

  assign force_if = (starve_q == CNT_W'(STARVE_MAX));

  always_comb begin
    o_gnt    = '0;
    starve_d = starve_q;
    if (i_en) begin
      if (i_req[REQ_IF] && (force_if || !i_req[REQ_D])) o_gnt[REQ_IF] = 1'b1;
      else if (i_req[REQ_D])                           o_gnt[REQ_D]  = 1'b1;
      // IF either won or did not ask: history is wiped; otherwise it lost to D.
      if (!i_req[REQ_IF] || o_gnt[REQ_IF]) starve_d = '0;
      else if (!force_if)                  starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) starve_q <= '0;
    else       starve_q <= starve_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and LSU, one transaction in flight.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_valid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_d_req,
  input  logic                i_d_wen,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  input  logic [DATA_W/8-1:0] i_d_mask,
  output logic                o_d_gnt,
  output logic                o_d_valid,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_mem_req,
  output logic                o_mem_wen,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_mask,
  input  logic                i_mem_valid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_timeout
);

  if (STARVE_MAX < 1 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("mem_port_arbiter: need STARVE_MAX >= 1 and TIMEOUT_CYC >= 2");
  end

  logic [1:0]          state_q, state_d;
  logic [NUM_REQ-1:0]  req, gnt;
  logic                arb_en, tmo_hit;
  logic                mem_req_q, mem_req_d, mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0] mem_mask_q, mem_mask_d;
  logic                if_valid_q, if_valid_d, d_valid_q, d_valid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic                timeout_q, timeout_d;

  assign arb_en         = (state_q == ST_IDLE);
  assign req[REQ_IF]    = i_if_req;
  assign req[REQ_D]     = i_d_req;

  arb_prio_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (arb_en),
    .i_req (req),
    .o_gnt (gnt)
  );

  // A grant would be thrown away by the reset, so do not tell the requester it was taken.
  assign o_if_gnt = gnt[REQ_IF] & ~i_rst;
  assign o_d_gnt  = gnt[REQ_D]  & ~i_rst;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_cnt_d = arb_en ? '0 : tmo_cnt_q + 1'b1;
  assign tmo_hit   = !arb_en && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) tmo_cnt_q <= '0;
    else       tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = 1'b0;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    timeout_d   = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt[REQ_IF]) begin
          state_d     = ST_BUSY_IF;
          mem_req_d   = 1'b1;
          mem_wen_d   = 1'b0;
          mem_addr_d  = i_if_addr;
          mem_wdata_d = '0;
          mem_mask_d  = '0;
        end else if (gnt[REQ_D]) begin
          state_d     = ST_BUSY_D;
          mem_req_d   = 1'b1;
          mem_wen_d   = i_d_wen;
          mem_addr_d  = i_d_addr;
          mem_wdata_d = i_d_wdata;
          mem_mask_d  = i_d_mask;
        end
      end
      ST_BUSY_IF, ST_BUSY_D: begin
        if (i_mem_valid || tmo_hit) begin
          state_d = ST_IDLE;
          // A watchdog expiry still completes the request, with zero data, so the requester unblocks.
          if (state_q == ST_BUSY_IF) begin
            if_valid_d = 1'b1;
            if_rdata_d = i_mem_valid ? i_mem_rdata : '0;
          end else begin
            d_valid_d  = 1'b1;
            d_rdata_d  = i_mem_valid ? i_mem_rdata : '0;
          end
          if (!i_mem_valid) timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_wen   = mem_wen_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_mask  = mem_mask_q;
  assign o_if_valid  = if_valid_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_d_valid   = d_valid_q;
  assign o_d_rdata   = d_rdata_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level reference model compared every cycle,
// plus literal timing/value expectations. Watchdog scenario runs when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MW = 4, SMAX = 4, TCYC = 8;
  localparam int OWN_NONE = 0, OWN_IF = 1, OWN_D = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 0, d_req = 0, d_wen = 0, mem_valid = 0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic [MW-1:0] d_mask = '0;
  logic if_gnt, if_valid, d_gnt, d_valid, mem_req, mem_wen, timeout;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_mask;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT_CYC(TCYC)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt), .o_if_valid(if_valid), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_wen(d_wen), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_mask(d_mask),
    .o_d_gnt(d_gnt), .o_d_valid(d_valid), .o_d_rdata(d_rdata),
    .o_mem_req(mem_req), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_mask(mem_mask), .i_mem_valid(mem_valid), .i_mem_rdata(mem_rdata), .o_timeout(timeout)
  );

  int checks = 0, errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model: who owns the port, how long IF has waited ----------------
  int owner = OWN_NONE, starve = 0, tcnt = 0;
  bit model_live = 0;
  logic e_mem_req, e_mem_wen, e_if_valid, e_d_valid, e_timeout;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata, e_if_rdata, e_d_rdata;
  logic [MW-1:0] e_mem_mask;

  function automatic bit if_wins();
    return if_req && (!d_req || starve == SMAX);
  endfunction

  always @(posedge clk) begin : model
    model_live <= 1'b1;
    if (rst) begin
      owner <= OWN_NONE; starve <= 0; tcnt <= 0;
      e_mem_req <= 0; e_mem_wen <= 0; e_mem_addr <= '0; e_mem_wdata <= '0; e_mem_mask <= '0;
      e_if_valid <= 0; e_d_valid <= 0; e_if_rdata <= '0; e_d_rdata <= '0; e_timeout <= 0;
    end else begin
      e_mem_req <= 0; e_if_valid <= 0; e_d_valid <= 0;
      if (owner == OWN_NONE) begin
        if (if_wins() || !if_req) starve <= 0;
        else                      starve <= (starve + 1 > SMAX) ? SMAX : starve + 1;
        if (if_wins()) begin
          owner <= OWN_IF; tcnt <= 0; e_mem_req <= 1;
          e_mem_wen <= 0; e_mem_addr <= if_addr; e_mem_wdata <= '0; e_mem_mask <= '0;
        end else if (d_req) begin
          owner <= OWN_D; tcnt <= 0; e_mem_req <= 1;
          e_mem_wen <= d_wen; e_mem_addr <= d_addr; e_mem_wdata <= d_wdata; e_mem_mask <= d_mask;
        end
      end else if (mem_valid) begin
        if (owner == OWN_IF) begin e_if_valid <= 1; e_if_rdata <= mem_rdata; end
        else                 begin e_d_valid  <= 1; e_d_rdata  <= mem_rdata; end
        owner <= OWN_NONE;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      else if (tcnt + 1 == TCYC) begin
        if (owner == OWN_IF) begin e_if_valid <= 1; e_if_rdata <= '0; end
        else                 begin e_d_valid  <= 1; e_d_rdata  <= '0; end
        e_timeout <= 1; owner <= OWN_NONE;
      end else tcnt <= tcnt + 1;
`endif
    end
  end

  // ---------------- compare + event log, away from the active edge ----------------
  int gnt_log[$];
  int mreq_cyc = -1, ifv_cyc = -1, dv_cyc = -1, ifv_cnt = 0, dv_cnt = 0;

  always @(negedge clk) begin
    if (model_live) begin
      chk("if_gnt",    if_gnt,    !rst && owner == OWN_NONE && if_wins());
      chk("d_gnt",     d_gnt,     !rst && owner == OWN_NONE && d_req && !if_wins());
      chk("mem_req",   mem_req,   e_mem_req);
      chk("mem_wen",   mem_wen,   e_mem_wen);
      chk("mem_addr",  mem_addr,  e_mem_addr);
      chk("mem_wdata", mem_wdata, e_mem_wdata);
      chk("mem_mask",  mem_mask,  e_mem_mask);
      chk("if_valid",  if_valid,  e_if_valid);
      chk("if_rdata",  if_rdata,  e_if_rdata);
      chk("d_valid",   d_valid,   e_d_valid);
      chk("d_rdata",   d_rdata,   e_d_rdata);
      chk("timeout",   timeout,   e_timeout);
    end
    if (if_gnt) gnt_log.push_back(OWN_IF);
    if (d_gnt)  gnt_log.push_back(OWN_D);
    if (mem_req) mreq_cyc = cyc;
    if (if_valid) begin ifv_cyc = cyc; ifv_cnt++; end
    if (d_valid)  begin dv_cyc  = cyc; dv_cnt++;  end
  end

  // ---------------- memory responder ----------------
  bit auto_en = 0, poke = 0;
  int lat = 1, pend = 0;

  always begin
    @(posedge clk); #2;
    mem_valid = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin mem_valid = 1; mem_rdata = mem_addr ^ 32'hA5A5_0000; end
    end
    if (auto_en && mem_req) pend = lat;
    if (poke) begin mem_valid = 1; mem_rdata = 32'hBAD0_BAD0; poke = 0; end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_gnt(input bit is_d, output int gc);
    gc = -1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (is_d ? d_gnt : if_gnt) begin gc = cyc; break; end
      tick();
    end
    if (gc < 0) begin
      checks++; errors++;
      $display("FAIL wait_gnt: no %s grant within 40 cycles", is_d ? "D" : "IF");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, v0, w0;
    int exp2[10];
    exp2 = '{OWN_D, OWN_D, OWN_D, OWN_D, OWN_IF, OWN_D, OWN_D, OWN_D, OWN_D, OWN_IF};

    repeat (3) tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_valids", {if_valid, d_valid}, 0);
    chk("rst_timeout", timeout, 0);
    rst = 0;
    tick();

    // 1: single fetch, memory answers 2 cycles after the request pulse
    auto_en = 1; lat = 2;
    if_addr = 32'h100; if_req = 1;
    wait_gnt(0, n);
    tick(); if_req = 0;
    repeat (6) tick();
    chk("t1_mem_req_cyc", mreq_cyc, n + 1);
    chk("t1_if_valid_cyc", ifv_cyc, n + 4);
    chk("t1_if_rdata", if_rdata, 32'hA5A5_0100);
    chk("t1_mem_mask", mem_mask, 0);

    // 2: both requesting back-to-back; starvation forces every fifth grant to IF
    lat = 1; gnt_log.delete();
    d_addr = 32'h300; d_wen = 0; if_addr = 32'h104;
    if_req = 1; d_req = 1;
    for (int k = 0; k < 300 && gnt_log.size() < 10; k++) tick();
    if_req = 0; d_req = 0;
    repeat (6) tick();
    chk("t2_grant_count", (gnt_log.size() >= 10), 1);
    if (gnt_log.size() >= 10)
      for (int i = 0; i < 10; i++) chk($sformatf("t2_order[%0d]", i), gnt_log[i], exp2[i]);

    // 3: store carries wen/addr/data/mask and acknowledges once
    d_wen = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_mask = 4'b0011; d_req = 1;
    v0 = dv_cnt;
    wait_gnt(1, n);
    tick(); d_req = 0;
    chk("t3_mem_req", mem_req, 1);
    chk("t3_mem_wen", mem_wen, 1);
    chk("t3_mem_addr", mem_addr, 32'h200);
    chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t3_mem_mask", mem_mask, 4'b0011);
    repeat (6) tick();
    chk("t3_d_valid_pulses", dv_cnt - v0, 1);
    d_wen = 0; d_mask = '0; d_wdata = '0;

    // 4: stray i_mem_valid while idle
    auto_en = 0; v0 = dv_cnt; w0 = ifv_cnt;
    poke = 1;
    repeat (4) tick();
    chk("t4_no_d_valid", dv_cnt - v0, 0);
    chk("t4_no_if_valid", ifv_cnt - w0, 0);
    auto_en = 1; if_addr = 32'h140; if_req = 1; #1;
    chk("t4_idle_gnt", if_gnt, 1);
    tick(); if_req = 0;
    repeat (5) tick();

    // 5: reset while BUSY_D, late response afterwards is ignored
    auto_en = 0; d_addr = 32'h400; d_req = 1;
    wait_gnt(1, n);
    tick(); d_req = 0;
    tick(); rst = 1;
    tick(); rst = 0;
    chk("t5_mem_req", mem_req, 0);
    chk("t5_mem_addr", mem_addr, 0);
    chk("t5_d_valid", d_valid, 0);
    chk("t5_d_rdata", d_rdata, 0);
    v0 = dv_cnt;
    tick(); poke = 1;
    repeat (4) tick();
    chk("t5_late_valid_ignored", dv_cnt - v0, 0);
    auto_en = 1; if_addr = 32'h180; if_req = 1; #1;
    chk("t5_if_gnt", if_gnt, 1);
    tick(); if_req = 0;
    repeat (5) tick();
    chk("t5_if_rdata", if_rdata, 32'hA5A5_0180);

`ifdef MEM_ARB_TIMEOUT_EN
    // 6: silent memory, watchdog completes the load with zero data
    auto_en = 0; d_addr = 32'h500; d_req = 1;
    wait_gnt(1, n);
    tick(); d_req = 0;
    repeat (12) tick();
    chk("t6_d_valid_cyc", dv_cyc, n + 1 + TCYC);
    chk("t6_d_rdata", d_rdata, 0);
    chk("t6_timeout", timeout, 1);
    auto_en = 1; if_addr = 32'h1C0; if_req = 1;
    wait_gnt(0, n);
    tick(); if_req = 0;
    repeat (5) tick();
    chk("t6_timeout_sticky", timeout, 1);
`else
    chk("timeout_tied_low", timeout, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
